motion_queue_sequencer: RTL and testbench
=========================================

MOTION_QUEUE_SEQUENCER -- requirements
Module: motion_queue_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the command FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have parameter WATCHDOG_CYCLES, default 32'd500_000_000, meaning the maximum clk cycles allowed per move before a fault.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), meaning the command push handshake.
REQ-006 The block SHALL have port cmd_speed, input, 32, meaning the requested feed speed in microsteps/s.
REQ-007 The block SHALL have ports cmd_num_x, cmd_num_y, cmd_num_z, cmd_num_e0 and cmd_num_e1, input, 32 signed each, meaning the per-axis relative move in microsteps.
REQ-008 The block SHALL have port speed, output, 32, meaning the speed of the active move, held stable while a move runs.
REQ-009 The block SHALL have ports num_x_m, num_y_m, num_z_m, num_e0_m and num_e1_m, output, 32 signed each, meaning the active move, held stable while a move runs.
REQ-010 The block SHALL have port start_driving_main, output, 1, meaning the level request to the motion datapath.
REQ-011 The block SHALL have ports finish (input, 1) and error (input, 1), meaning the completion and endstop-error status from the datapath.
REQ-012 The block SHALL have ports enable_steppers (output, 1) and disable_steppers (output, 1), meaning one-cycle driver enable and disable pulses.
REQ-013 The block SHALL have ports busy (output, 1), queue_count (output, $clog2(DEPTH)+1), fault (output, 1) and fault_code (output, 2), meaning the block status.
REQ-014 The block SHALL have port fault_clear, input, 1, meaning the request to leave FAULT.

Function
REQ-015 A push SHALL occur on a rising clk edge when cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal 1 when the FIFO is not full and state is not FAULT.
REQ-016 Pops and pushes in the same cycle SHALL both take effect, with queue_count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-017 The FSM states SHALL be IDLE, ENABLE, LOAD, RUN, GAP and FAULT.
REQ-018 IDLE SHALL go to ENABLE if the FIFO is non-empty and the drivers are off, to LOAD if the FIFO is non-empty and the drivers are on, and otherwise stay in IDLE.
REQ-019 ENABLE SHALL pulse enable_steppers for exactly 1 cycle, set the internal drv_on flag to 1, and go to LOAD.
REQ-020 LOAD SHALL pop the head entry into the speed and num_*_m output registers.
REQ-021 LOAD SHALL go to GAP without asserting start_driving_main if all five num values are 0 (null move); otherwise it SHALL go to RUN.
REQ-022 RUN SHALL hold start_driving_main=1 and keep the output registers frozen.
REQ-023 RUN SHALL go to GAP on finish=1 with error=0, and to FAULT with fault_code=2'd1 on finish=1 with error=1.
REQ-024 GAP SHALL drive start_driving_main=0 for exactly 1 cycle, then go to LOAD if the FIFO is non-empty, or to IDLE otherwise.
REQ-025 Latency from a push into an empty FIFO with drv_on=1 to start_driving_main=1 SHALL be 2 cycles; with drv_on=0 it SHALL be 3 cycles.
REQ-026 On entry, FAULT SHALL flush the FIFO, drop start_driving_main, pulse disable_steppers for 1 cycle, clear drv_on and set fault=1.
REQ-027 FAULT SHALL be left only on fault_clear=1, which clears fault and fault_code and goes to IDLE; fault_clear in any other state SHALL be ignored.
REQ-028 busy SHALL equal 1 in every state except IDLE and FAULT.
REQ-029 A finish or error arriving outside RUN SHALL be ignored.

Reset
REQ-030 When reset=0 the block SHALL asynchronously clear the FIFO pointers, queue_count, start_driving_main, enable_steppers, disable_steppers, fault, fault_code, busy, drv_on, speed and all num_*_m to 0, and set state to IDLE.
REQ-031 When reset=0, cmd_ready SHALL be 0.
REQ-032 A reset during RUN SHALL drop start_driving_main immediately and emit no disable_steppers pulse.

Configuration
REQ-033 With MOTION_QUEUE_WATCHDOG_EN defined, a 32-bit counter SHALL clear on RUN entry and increment each RUN cycle; reaching WATCHDOG_CYCLES without finish SHALL go to FAULT with fault_code=2'd2.
REQ-034 Without MOTION_QUEUE_WATCHDOG_EN, the watchdog counter SHALL be absent, RUN SHALL wait indefinitely, and fault_code SHALL never equal 2'd2.

Verification
REQ-035 The bench SHALL cover: reset release, push 1 move (x=100) -> enable_steppers pulse at cycle 1, start_driving_main=1 at cycle 3; finish pulse -> 1-cycle GAP, then IDLE.
REQ-036 The bench SHALL cover: 5 pushes with DEPTH=4 and RUN stalled -> 5th push blocked (cmd_ready=0); queue_count=4 after the first pop settles back to 3; all moves execute in order.
REQ-037 The bench SHALL cover: finish=1 and error=1 in RUN -> FAULT, disable_steppers 1-cycle pulse, FIFO flushed, fault_code=1; fault_clear -> IDLE, and the next push re-pulses enable_steppers.
REQ-038 The bench SHALL cover: push of an all-zero move followed by x=50 -> no start for the null move; x=50 starts 2 cycles after the null-move GAP.
REQ-039 The bench SHALL cover: with WATCHDOG_EN and WATCHDOG_CYCLES=10, no finish -> FAULT with fault_code=2 after 10 RUN cycles; reset=0 mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/motion_queue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motion_queue_sequencer
// Purpose  : Buffers relative multi-axis move commands in a small FIFO and
//            sequences them one at a time into the motion datapath. Drives the
//            stepper enable/disable pulses and traps datapath errors in FAULT.
// Ports    : clk, reset (async, active-low)
//            cmd_valid/cmd_ready + cmd_speed, cmd_num_{x,y,z,e0,e1} : push side
//            speed, num_{x,y,z,e0,e1}_m, start_driving_main          : active move
//            finish, error                                           : datapath status
//            enable_steppers, disable_steppers                       : 1-cycle pulses
//            busy, queue_count, fault, fault_code, fault_clear       : status/control
// Options  : MOTION_QUEUE_WATCHDOG_EN enables the per-move RUN timeout
//            (fault_code 2'd2 after WATCHDOG_CYCLES cycles in RUN).
// Revision : 1.0 - initial release
// ============================================================================
module motion_queue_sequencer #(
  parameter int unsigned DEPTH           = 4,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd500_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [31:0]               cmd_speed,
  input  logic signed [31:0]        cmd_num_x,
  input  logic signed [31:0]        cmd_num_y,
  input  logic signed [31:0]        cmd_num_z,
  input  logic signed [31:0]        cmd_num_e0,
  input  logic signed [31:0]        cmd_num_e1,
  output logic [31:0]               speed,
  output logic signed [31:0]        num_x_m,
  output logic signed [31:0]        num_y_m,
  output logic signed [31:0]        num_z_m,
  output logic signed [31:0]        num_e0_m,
  output logic signed [31:0]        num_e1_m,
  output logic                      start_driving_main,
  input  logic                      finish,
  input  logic                      error,
  output logic                      enable_steppers,
  output logic                      disable_steppers,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    queue_count,
  output logic                      fault,
  output logic [1:0]                fault_code,
  input  logic                      fault_clear
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned EW         = 192;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENABLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_GAP    = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                drv_on_q, drv_on_d;
  logic                start_q, start_d;
  logic                enable_q, enable_d;
  logic                disable_q, disable_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic [31:0]         speed_q, speed_d;
  logic signed [31:0]  num_x_q, num_x_d, num_y_q, num_y_d, num_z_q, num_z_d;
  logic signed [31:0]  num_e0_q, num_e0_d, num_e1_q, num_e1_d;

  logic [EW-1:0]       fifo_mem [DEPTH];
  logic [EW-1:0]       w_head;
  logic                w_empty, w_full, w_push, w_pop, w_null_move, w_wd_expired;

  assign w_empty     = (count_q == '0);
  assign w_full      = (count_q == FULL_COUNT);
  // Gated by reset so the producer never sees ready while the block is held.
  assign cmd_ready   = reset & ~w_full & (state_q != ST_FAULT);
  assign w_push      = cmd_valid & cmd_ready;
  assign w_pop       = (state_q == ST_LOAD) & ~w_empty;
  assign w_head      = fifo_mem[rd_ptr_q];
  // All five axis counts zero: nothing for the datapath to do.
  assign w_null_move = ~|w_head[159:0];

  // Storage is data-only; validity is tracked by the reset pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem[wr_ptr_q] <= {cmd_speed, cmd_num_x, cmd_num_y, cmd_num_z,
                             cmd_num_e0, cmd_num_e1};
    end
  end

`ifdef MOTION_QUEUE_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;

  // Held at zero outside RUN, so every RUN entry starts counting from 0.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == ST_RUN) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
    end
  end

  assign w_wd_expired = (state_q == ST_RUN) && (wd_cnt_d >= WATCHDOG_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  // RUN never times out in this build; the parameter stays on the interface.
  assign w_wd_expired = 1'b0 & (|WATCHDOG_CYCLES);
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drv_on_d     = drv_on_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    speed_d      = speed_q;
    num_x_d      = num_x_q;
    num_y_d      = num_y_q;
    num_z_d      = num_z_q;
    num_e0_d     = num_e0_q;
    num_e1_d     = num_e1_q;
    disable_d    = 1'b0;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!w_empty) state_d = drv_on_q ? ST_LOAD : ST_ENABLE;
      end
      ST_ENABLE: begin
        drv_on_d = 1'b1;
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        {speed_d, num_x_d, num_y_d, num_z_d, num_e0_d, num_e1_d} = w_head;
        state_d = w_null_move ? ST_GAP : ST_RUN;
      end
      ST_RUN: begin
        if (finish) begin
          if (error) begin
            state_d      = ST_FAULT;
            fault_code_d = 2'd1;
          end else begin
            state_d = ST_GAP;
          end
        end else if (w_wd_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = 2'd2;
        end
      end
      ST_GAP: begin
        state_d = w_empty ? ST_IDLE : ST_LOAD;
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_d      = ST_IDLE;
          fault_d      = 1'b0;
          fault_code_d = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // FAULT entry: flush wins over any push accepted on the same edge.
    if (state_d == ST_FAULT && state_q != ST_FAULT) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      drv_on_d  = 1'b0;
      fault_d   = 1'b1;
      disable_d = 1'b1;
    end

    // Outputs are registered from the next state so they align with it.
    start_d  = (state_d == ST_RUN);
    enable_d = (state_d == ST_ENABLE);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drv_on_q     <= 1'b0;
      start_q      <= 1'b0;
      enable_q     <= 1'b0;
      disable_q    <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
      speed_q      <= '0;
      num_x_q      <= '0;
      num_y_q      <= '0;
      num_z_q      <= '0;
      num_e0_q     <= '0;
      num_e1_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drv_on_q     <= drv_on_d;
      start_q      <= start_d;
      enable_q     <= enable_d;
      disable_q    <= disable_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      speed_q      <= speed_d;
      num_x_q      <= num_x_d;
      num_y_q      <= num_y_d;
      num_z_q      <= num_z_d;
      num_e0_q     <= num_e0_d;
      num_e1_q     <= num_e1_d;
    end
  end

  assign start_driving_main = start_q;
  assign enable_steppers    = enable_q;
  assign disable_steppers   = disable_q;
  assign busy               = busy_q;
  assign queue_count        = count_q;
  assign fault              = fault_q;
  assign fault_code         = fault_code_q;
  assign speed              = speed_q;
  assign num_x_m            = num_x_q;
  assign num_y_m            = num_y_q;
  assign num_z_m            = num_z_q;
  assign num_e0_m           = num_e0_q;
  assign num_e1_m           = num_e1_q;

endmodule
`default_nettype wire

// File: tb/tb_motion_queue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_queue_sequencer
// Purpose  : Scoreboard bench for motion_queue_sequencer. Accepted non-null
//            moves are queued as expected datapath loads; a monitor compares
//            the active-move registers at every rising start_driving_main.
//            Directed sequences check timing, back-pressure, faults and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motion_queue_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid, cmd_ready;
  logic [31:0]        cmd_speed;
  logic signed [31:0] cmd_num_x, cmd_num_y, cmd_num_z, cmd_num_e0, cmd_num_e1;
  logic [31:0]        speed;
  logic signed [31:0] num_x_m, num_y_m, num_z_m, num_e0_m, num_e1_m;
  logic               start_driving_main, finish, error;
  logic               enable_steppers, disable_steppers, busy, fault, fault_clear;
  logic [2:0]         queue_count;
  logic [1:0]         fault_code;

  always #5 clk = ~clk;

  motion_queue_sequencer #(.DEPTH(4), .WATCHDOG_CYCLES(32'd10)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_speed(cmd_speed),
    .cmd_num_x(cmd_num_x), .cmd_num_y(cmd_num_y), .cmd_num_z(cmd_num_z),
    .cmd_num_e0(cmd_num_e0), .cmd_num_e1(cmd_num_e1),
    .speed(speed), .num_x_m(num_x_m), .num_y_m(num_y_m), .num_z_m(num_z_m),
    .num_e0_m(num_e0_m), .num_e1_m(num_e1_m),
    .start_driving_main(start_driving_main), .finish(finish), .error(error),
    .enable_steppers(enable_steppers), .disable_steppers(disable_steppers),
    .busy(busy), .queue_count(queue_count), .fault(fault),
    .fault_code(fault_code), .fault_clear(fault_clear)
  );

  typedef struct packed {
    logic [31:0]        spd;
    logic signed [31:0] x, y, z, e0, e1;
  } move_t;

  move_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic move_t mk(input int s, input int x, input int y, input int z,
                               input int e0, input int e1);
    move_t m;
    m.spd = s; m.x = x; m.y = y; m.z = z; m.e0 = e0; m.e1 = e1;
    return m;
  endfunction

  // Monitor: every new move start must match the head of the scoreboard.
  logic start_prev = 1'b0, en_prev = 1'b0, dis_prev = 1'b0;
  always @(negedge clk) begin
    if (start_driving_main && !start_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_start: got speed %0h with no move expected", speed);
      end else begin
        check("move_speed", speed,    exp_q[0].spd);
        check("move_x",     num_x_m,  exp_q[0].x);
        check("move_y",     num_y_m,  exp_q[0].y);
        check("move_z",     num_z_m,  exp_q[0].z);
        check("move_e0",    num_e0_m, exp_q[0].e0);
        check("move_e1",    num_e1_m, exp_q[0].e1);
        void'(exp_q.pop_front());
      end
    end
    if (en_prev)  check("enable_pulse_width",  enable_steppers,  1'b0);
    if (dis_prev) check("disable_pulse_width", disable_steppers, 1'b0);
    start_prev <= start_driving_main;
    en_prev    <= enable_steppers;
    dis_prev   <= disable_steppers;
  end

  task automatic push(input move_t m);
    int n;
    n = 0;
    @(negedge clk);
    cmd_speed = m.spd; cmd_num_x = m.x; cmd_num_y = m.y;
    cmd_num_z = m.z; cmd_num_e0 = m.e0; cmd_num_e1 = m.e1;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 1'b0, 1'b1);
      cmd_valid = 1'b0;
    end else begin
      if (m[159:0] != '0) exp_q.push_back(m);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    @(negedge clk);
    while (!start_driving_main && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!start_driving_main) check("wait_start_timeout", 1'b0, 1'b1);
  endtask

  task automatic finish_move();
    wait_start();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 1'b0, 1'b1);
  endtask

  // Checks cycles 0..3 after a push into an empty FIFO with drivers off.
  task automatic check_cold_start(input string tag);
    @(negedge clk);
    check({tag, "_count_c0"}, queue_count, 3'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check({tag, "_enable"}, enable_steppers, (k == 1));
      check({tag, "_start"},  start_driving_main, (k == 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; finish = 1'b0; error = 1'b0; fault_clear = 1'b0;
    cmd_speed = '0; cmd_num_x = '0; cmd_num_y = '0; cmd_num_z = '0;
    cmd_num_e0 = '0; cmd_num_e1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {start_driving_main, enable_steppers, disable_steppers, busy,
                         fault, fault_code, queue_count, cmd_ready}, '0);
    check("reset_data", speed | num_x_m | num_y_m | num_z_m | num_e0_m | num_e1_m, '0);
    reset = 1'b1;
    #1;
    check("release_ready", cmd_ready, 1'b1);
    check("release_busy",  busy, 1'b0);

    // Single move from cold: enable at cycle 1, start at cycle 3, GAP then IDLE
    push(mk(1000, 100, 0, 0, 0, 0));
    check_cold_start("t1");
    repeat (3) @(negedge clk);
    check("t1_run_hold", start_driving_main, 1'b1);
    check("t1_run_frozen_x", num_x_m, 32'sd100);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("t1_gap_start", start_driving_main, 1'b0);
    check("t1_gap_busy",  busy, 1'b1);
    @(negedge clk);
    check("t1_idle_busy",  busy, 1'b0);
    check("t1_idle_start", start_driving_main, 1'b0);

    // finish/error outside RUN are ignored
    finish = 1'b1; error = 1'b1;
    @(negedge clk);
    finish = 1'b0; error = 1'b0;
    @(negedge clk);
    check("idle_error_ignored", {fault, fault_code, busy}, '0);

    // Back-pressure with RUN stalled, then in-order execution
    push(mk(100, 1, -1, 2, 11, -21));
    wait_start();
    for (int i = 2; i <= 5; i++) push(mk(100*i, i, -i, 2*i, i+10, -(i+20)));
    @(negedge clk);
    check("t2_count_full", queue_count, 3'd4);
    cmd_speed = 32'd600; cmd_num_x = 32'sd6; cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_fifth_blocked", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("t2_count_gap", queue_count, 3'd4);
    @(negedge clk);
    check("t2_count_load", queue_count, 3'd4);
    @(negedge clk);
    check("t2_count_after_pop", queue_count, 3'd3);
    check("t2_restart", start_driving_main, 1'b1);
    push(mk(600, 6, -6, 12, 16, -26));
    for (int i = 2; i <= 6; i++) finish_move();
    wait_idle();
    check("t2_all_moves_done", exp_q.size(), 0);

    // Endstop error in RUN -> FAULT, flush, clear, cold restart
    push(mk(700, 7, 0, 0, 0, 0));
    wait_start();
    push(mk(800, 8, 0, 0, 0, 0));
    @(negedge clk);
    check("t3_count_before", queue_count, 3'd1);
    finish = 1'b1; error = 1'b1;
    @(negedge clk);
    finish = 1'b0; error = 1'b0;
    exp_q.delete();
    check("t3_fault",      fault, 1'b1);
    check("t3_fault_code", fault_code, 2'd1);
    check("t3_disable",    disable_steppers, 1'b1);
    check("t3_start_drop", start_driving_main, 1'b0);
    check("t3_flushed",    queue_count, 3'd0);
    check("t3_ready_low",  cmd_ready, 1'b0);
    check("t3_busy",       busy, 1'b0);
    @(negedge clk);
    check("t3_fault_held", {fault, fault_code}, {1'b1, 2'd1});
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    check("t3_cleared",       {fault, fault_code}, '0);
    check("t3_ready_restore", cmd_ready, 1'b1);
    push(mk(900, 9, 0, 0, 0, 0));
    check_cold_start("t3");
    finish_move();
    wait_idle();

    // Null move is skipped; x=50 starts 2 cycles after its GAP
    push(mk(77, 0, 0, 0, 0, 0));
    push(mk(500, 50, 0, 0, 0, 0));
    @(negedge clk);
    check("t4_load_null", start_driving_main, 1'b0);
    @(negedge clk);
    check("t4_gap_start", start_driving_main, 1'b0);
    check("t4_gap_speed", speed, 32'd77);
    check("t4_gap_busy",  busy, 1'b1);
    @(negedge clk);
    check("t4_load_x50", start_driving_main, 1'b0);
    @(negedge clk);
    check("t4_run_x50", start_driving_main, 1'b1);
    finish_move();
    wait_idle();

`ifdef MOTION_QUEUE_WATCHDOG_EN
    begin
      int n;
      push(mk(1100, 11, 0, 0, 0, 0));
      wait_start();
      n = 1;
      @(negedge clk);
      while (start_driving_main && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("t5_wd_run_cycles", n, 10);
      check("t5_wd_fault_code", fault_code, 2'd2);
      check("t5_wd_disable",    disable_steppers, 1'b1);
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      push(mk(1200, 12, 0, 0, 0, 0));
      wait_start();
    end
`else
    push(mk(1100, 11, 0, 0, 0, 0));
    wait_start();
    repeat (30) @(negedge clk);
    check("t5_run_waits",    start_driving_main, 1'b1);
    check("t5_no_wd_fault",  {fault, fault_code}, '0);
`endif

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_async_ctrl", {start_driving_main, enable_steppers, disable_steppers, busy,
                            fault, fault_code, queue_count, cmd_ready}, '0);
    check("t6_async_data", speed | num_x_m | num_y_m | num_z_m | num_e0_m | num_e1_m, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_disable", disable_steppers, 1'b0);
    end
    check("t6_idle", {busy, start_driving_main}, '0);
    check("sb_empty_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
